// File: rtl/sccb_responder.sv
// SCCB/I2C target modelling the OV7670 register port: 256x8 register file.
// Define SCCB_RESP_AUTOINC_EN for multi-byte bursts with pointer auto-increment.
module sccb_responder #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sioc,
  input  logic       siod_i,
  output logic       siod_oe,
  input  logic [7:0] reg_rd_addr,
  output logic [7:0] reg_rd_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_ID_ACK   = 4'd2;
  localparam logic [3:0] S_SUB      = 4'd3;
  localparam logic [3:0] S_SUB_ACK  = 4'd4;
  localparam logic [3:0] S_DATA     = 4'd5;
  localparam logic [3:0] S_DATA_ACK = 4'd6;
  localparam logic [3:0] S_RD       = 4'd7;
  localparam logic [3:0] S_RD_NACK  = 4'd8;
  localparam logic [3:0] S_IGNORE   = 4'd9;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   rise;
  logic                   fall;
  logic                   start;
  logic                   stop;

  logic [3:0] state;
  logic [3:0] bitcnt;
  logic [1:0] ph;
  logic       rd;
  logic [6:0] shreg;
  logic [7:0] byte_nx;
  logic [7:0] tx;
  logic [7:0] pointer;
  logic       last_bit;
  logic       wr_en;
  logic [7:0] regs [256];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], sioc};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], siod_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign rise     = scl_s & ~scl_q;
  assign fall     = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_nx  = {shreg, sda_s};
  assign last_bit = rise && (bitcnt == 4'd7);
  assign wr_en    = (state == S_DATA) && last_bit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[pointer] <= byte_nx;
    end
  end

  assign reg_rd_data = regs[reg_rd_addr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      bitcnt    <= 4'd0;
      ph        <= 2'd0;
      rd        <= 1'b0;
      shreg     <= 7'd0;
      tx        <= 8'd0;
      pointer   <= 8'd0;
      siod_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (start) begin
        state   <= S_ID;
        bitcnt  <= 4'd0;
        ph      <= 2'd0;
        siod_oe <= 1'b0;
        busy    <= 1'b1;
      end else if (stop) begin
        state   <= S_IDLE;
        bitcnt  <= 4'd0;
        ph      <= 2'd0;
        siod_oe <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_ID, S_SUB, S_DATA: begin
            if (rise) begin
              shreg  <= byte_nx[6:0];
              bitcnt <= bitcnt + 4'd1;
            end
            if (last_bit) begin
              bitcnt <= 4'd0;
              ph     <= 2'd0;
              if (state == S_ID) begin
                if (byte_nx == DEV_ID) begin
                  rd    <= 1'b0;
                  state <= S_ID_ACK;
                end else if (byte_nx == (DEV_ID | 8'h01)) begin
                  rd    <= 1'b1;
                  state <= S_ID_ACK;
                end else begin
                  state <= S_IGNORE;
                end
              end else if (state == S_SUB) begin
                pointer <= byte_nx;
                state   <= S_SUB_ACK;
              end else begin
                wr_addr   <= pointer;
                wr_data   <= byte_nx;
                wr_strobe <= 1'b1;
`ifdef SCCB_RESP_AUTOINC_EN
                pointer   <= pointer + 8'd1;
`endif
                state     <= S_DATA_ACK;
              end
            end
          end
          S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
            if (rise && ph == 2'd1) ph <= 2'd2;
            if (fall && ph == 2'd0) begin
              siod_oe <= 1'b1;
              ph      <= 2'd1;
            end else if (fall && ph == 2'd2) begin
              siod_oe <= 1'b0;
              ph      <= 2'd0;
              if (state == S_ID_ACK) begin
                if (rd) begin
                  // first read bit goes out on the same edge that ends the ack
                  tx      <= regs[pointer];
                  siod_oe <= ~regs[pointer][7];
                  state   <= S_RD;
                end else begin
                  state <= S_SUB;
                end
              end else if (state == S_SUB_ACK) begin
                state <= S_DATA;
              end else begin
`ifdef SCCB_RESP_AUTOINC_EN
                state <= S_DATA;
`else
                state <= S_IGNORE;
`endif
              end
            end
          end
          S_RD: begin
            if (rise) begin
              tx     <= {tx[6:0], 1'b0};
              bitcnt <= bitcnt + 4'd1;
            end
            if (fall) begin
              if (bitcnt == 4'd8) begin
                siod_oe <= 1'b0;
                bitcnt  <= 4'd0;
                ph      <= 2'd0;
                state   <= S_RD_NACK;
              end else begin
                siod_oe <= ~tx[7];
              end
            end
          end
          S_RD_NACK: begin
`ifdef SCCB_RESP_AUTOINC_EN
            if (rise) begin
              if (!sda_s) begin
                pointer <= pointer + 8'd1;
                ph      <= 2'd1;
              end else begin
                state <= S_IGNORE;
              end
            end
            if (fall && ph == 2'd1) begin
              tx      <= regs[pointer];
              siod_oe <= ~regs[pointer][7];
              ph      <= 2'd0;
              state   <= S_RD;
            end
`else
            if (rise) state <= S_IGNORE;
`endif
          end
          S_IDLE, S_IGNORE: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder acting as SCCB initiator on an
// open-drain bus model.
module tb_sccb_responder;

  logic       clk;
  logic       resetn;
  logic       sioc;
  logic       m_sda;
  logic       siod;
  logic       siod_oe;
  logic [7:0] reg_rd_addr;
  logic [7:0] reg_rd_data;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int oe_cnt   = 0;

  assign siod = m_sda & ~siod_oe;

  sccb_responder dut (
    .clk         (clk),
    .resetn      (resetn),
    .sioc        (sioc),
    .siod_i      (siod),
    .siod_oe     (siod_oe),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobes++;
    if (siod_oe === 1'b1) oe_cnt++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_n(4);
    m_sda = b;
    wait_n(6);
    sioc = 1'b1;
    wait_n(5);
    s = siod;
    wait_n(5);
    sioc = 1'b0;
  endtask

  task automatic sccb_start();
    wait_n(4);
    m_sda = 1'b1;
    wait_n(6);
    sioc = 1'b1;
    wait_n(10);
    m_sda = 1'b0;
    wait_n(10);
    sioc = 1'b0;
  endtask

  task automatic sccb_stop();
    wait_n(4);
    m_sda = 1'b0;
    wait_n(6);
    sioc = 1'b1;
    wait_n(10);
    m_sda = 1'b1;
    wait_n(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v,
                           output logic nine);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, d);
      v[i] = d;
    end
    clk_bit(mack, nine);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] v);
    logic k;
    sccb_start();
    send_byte(8'h42, k);
    send_byte(a, k);
    send_byte(v, k);
    sccb_stop();
  endtask

  task automatic test_reset();
    reg_rd_addr = 8'h12;
    #1;
    checks++;
    if (siod_oe !== 1'b0) begin
      failures++; $display("FAIL rst_oe got=%b exp=0", siod_oe);
    end
    checks++;
    if (wr_strobe !== 1'b0) begin
      failures++; $display("FAIL rst_strobe got=%b exp=0", wr_strobe);
    end
    checks++;
    if (wr_addr !== 8'h00) begin
      failures++; $display("FAIL rst_wr_addr got=%h exp=00", wr_addr);
    end
    checks++;
    if (wr_data !== 8'h00) begin
      failures++; $display("FAIL rst_wr_data got=%h exp=00", wr_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    checks++;
    if (reg_rd_data !== 8'h00) begin
      failures++; $display("FAIL rst_reg got=%h exp=00", reg_rd_data);
    end
  endtask

  task automatic test_write();
    logic a1, a2, a3;
    int s0;
    s0 = strobes;
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'h12, a2);
    send_byte(8'h80, a3);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL wr_busy got=%b exp=1", busy);
    end
    sccb_stop();
    checks++;
    if ({a1, a2, a3} !== 3'b000) begin
      failures++; $display("FAIL wr_acks got=%b exp=000", {a1, a2, a3});
    end
    checks++;
    if (strobes - s0 != 1) begin
      failures++; $display("FAIL wr_strobes got=%0d exp=1", strobes - s0);
    end
    checks++;
    if (wr_addr !== 8'h12) begin
      failures++; $display("FAIL wr_addr got=%h exp=12", wr_addr);
    end
    checks++;
    if (wr_data !== 8'h80) begin
      failures++; $display("FAIL wr_data got=%h exp=80", wr_data);
    end
    reg_rd_addr = 8'h12;
    #1;
    checks++;
    if (reg_rd_data !== 8'h80) begin
      failures++; $display("FAIL wr_reg got=%h exp=80", reg_rd_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL wr_busy_end got=%b exp=0", busy);
    end
  endtask

  task automatic test_wrong_id();
    logic a1, a2, a3;
    int s0, o0;
    s0 = strobes;
    o0 = oe_cnt;
    sccb_start();
    send_byte(8'h60, a1);
    send_byte(8'h12, a2);
    send_byte(8'h55, a3);
    sccb_stop();
    checks++;
    if ({a1, a2, a3} !== 3'b111) begin
      failures++; $display("FAIL id_acks got=%b exp=111", {a1, a2, a3});
    end
    checks++;
    if (oe_cnt != o0) begin
      failures++; $display("FAIL id_oe got=%0d exp=0", oe_cnt - o0);
    end
    checks++;
    if (strobes != s0) begin
      failures++; $display("FAIL id_strobe got=%0d exp=0", strobes - s0);
    end
    reg_rd_addr = 8'h12;
    #1;
    checks++;
    if (reg_rd_data !== 8'h80) begin
      failures++; $display("FAIL id_reg got=%h exp=80", reg_rd_data);
    end
  endtask

  task automatic test_read();
    logic a1, a2, a3, nine;
    logic [7:0] v;
    do_write(8'h3A, 8'hA5);
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'h3A, a2);
    sccb_stop();
    sccb_start();
    send_byte(8'h43, a3);
    recv_byte(1'b1, v, nine);
    sccb_stop();
    checks++;
    if ({a1, a2, a3} !== 3'b000) begin
      failures++; $display("FAIL rd_acks got=%b exp=000", {a1, a2, a3});
    end
    checks++;
    if (v !== 8'hA5) begin
      failures++; $display("FAIL rd_data got=%h exp=a5", v);
    end
    checks++;
    if (nine !== 1'b1) begin
      failures++; $display("FAIL rd_release got=%b exp=1", nine);
    end
    sccb_start();
    send_byte(8'h43, a1);
    recv_byte(1'b1, v, nine);
    sccb_stop();
    checks++;
    if (v !== 8'hA5) begin
      failures++; $display("FAIL rd_ptr_kept got=%h exp=a5", v);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rd_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_stop_repstart();
    logic k, nine;
    logic [7:0] v;
    int s0;
    s0 = strobes;
    sccb_start();
    send_byte(8'h42, k);
    send_byte(8'h12, k);
    for (int i = 0; i < 5; i++) clk_bit(1'b0, k);
    sccb_stop();
    checks++;
    if (strobes != s0) begin
      failures++; $display("FAIL part_strobe got=%0d exp=0", strobes - s0);
    end
    reg_rd_addr = 8'h12;
    #1;
    checks++;
    if (reg_rd_data !== 8'h80) begin
      failures++; $display("FAIL part_reg got=%h exp=80", reg_rd_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL part_busy got=%b exp=0", busy);
    end
    do_write(8'h20, 8'h5C);
    do_write(8'h21, 8'h11);
    sccb_start();
    send_byte(8'h42, k);
    send_byte(8'h20, k);
    sccb_start();
    send_byte(8'h43, k);
    checks++;
    if (k !== 1'b0) begin
      failures++; $display("FAIL rs_id_ack got=%b exp=0", k);
    end
    recv_byte(1'b1, v, nine);
    sccb_stop();
    checks++;
    if (v !== 8'h5C) begin
      failures++; $display("FAIL rs_data got=%h exp=5c", v);
    end
  endtask

  task automatic test_reset_mid();
    logic a1, a2, a3;
    do_write(8'h05, 8'h11);
    reg_rd_addr = 8'h05;
    #1;
    checks++;
    if (reg_rd_data !== 8'h11) begin
      failures++; $display("FAIL rm_pre got=%h exp=11", reg_rd_data);
    end
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'h05, a1);
    for (int i = 7; i >= 4; i--) clk_bit(1'b1, a1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (siod_oe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_now got=%b%b exp=00", siod_oe, busy);
    end
    checks++;
    if (reg_rd_data !== 8'h00) begin
      failures++; $display("FAIL rm_clear got=%h exp=00", reg_rd_data);
    end
    sioc = 1'b1;
    m_sda = 1'b1;
    wait_n(5);
    resetn = 1'b1;
    wait_n(5);
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'h05, a2);
    send_byte(8'h77, a3);
    sccb_stop();
    checks++;
    if ({a1, a2, a3} !== 3'b000) begin
      failures++; $display("FAIL rm_acks got=%b exp=000", {a1, a2, a3});
    end
    #1;
    checks++;
    if (reg_rd_data !== 8'h77) begin
      failures++; $display("FAIL rm_reg got=%h exp=77", reg_rd_data);
    end
    checks++;
    if (wr_addr !== 8'h05 || wr_data !== 8'h77) begin
      failures++;
      $display("FAIL rm_wr got=%h/%h exp=05/77", wr_addr, wr_data);
    end
  endtask

`ifdef SCCB_RESP_AUTOINC_EN
  task automatic test_autoinc();
    logic a1, a2, a3, a4, a5, nine;
    logic [7:0] v;
    int s0;
    s0 = strobes;
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'h10, a2);
    send_byte(8'h01, a3);
    send_byte(8'h02, a4);
    send_byte(8'h03, a5);
    sccb_stop();
    checks++;
    if ({a1, a2, a3, a4, a5} !== 5'b0) begin
      failures++; $display("FAIL ai_acks got=%b exp=00000", {a1, a2, a3, a4, a5});
    end
    checks++;
    if (strobes - s0 != 3) begin
      failures++; $display("FAIL ai_strobes got=%0d exp=3", strobes - s0);
    end
    for (int i = 0; i < 3; i++) begin
      reg_rd_addr = 8'(8'h10 + i);
      #1;
      checks++;
      if (reg_rd_data !== 8'(i + 1)) begin
        failures++;
        $display("FAIL ai_reg%0d got=%h exp=%h", i, reg_rd_data, 8'(i + 1));
      end
    end
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'hFF, a1);
    send_byte(8'hAA, a1);
    send_byte(8'hBB, a1);
    sccb_stop();
    reg_rd_addr = 8'hFF;
    #1;
    checks++;
    if (reg_rd_data !== 8'hAA) begin
      failures++; $display("FAIL ai_ff got=%h exp=aa", reg_rd_data);
    end
    reg_rd_addr = 8'h00;
    #1;
    checks++;
    if (reg_rd_data !== 8'hBB) begin
      failures++; $display("FAIL ai_wrap got=%h exp=bb", reg_rd_data);
    end
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'h10, a1);
    sccb_start();
    send_byte(8'h43, a1);
    recv_byte(1'b0, v, nine);
    checks++;
    if (v !== 8'h01) begin
      failures++; $display("FAIL ai_rd0 got=%h exp=01", v);
    end
    recv_byte(1'b1, v, nine);
    sccb_stop();
    checks++;
    if (v !== 8'h02) begin
      failures++; $display("FAIL ai_rd1 got=%h exp=02", v);
    end
  endtask
`else
  task automatic test_extra_byte();
    logic a1, a2, a3, a4;
    int s0;
    s0 = strobes;
    sccb_start();
    send_byte(8'h42, a1);
    send_byte(8'h30, a2);
    send_byte(8'h01, a3);
    send_byte(8'h02, a4);
    sccb_stop();
    checks++;
    if ({a1, a2, a3, a4} !== 4'b0001) begin
      failures++; $display("FAIL xb_acks got=%b exp=0001", {a1, a2, a3, a4});
    end
    checks++;
    if (strobes - s0 != 1) begin
      failures++; $display("FAIL xb_strobes got=%0d exp=1", strobes - s0);
    end
    reg_rd_addr = 8'h30;
    #1;
    checks++;
    if (reg_rd_data !== 8'h01) begin
      failures++; $display("FAIL xb_reg30 got=%h exp=01", reg_rd_data);
    end
    reg_rd_addr = 8'h31;
    #1;
    checks++;
    if (reg_rd_data !== 8'h00) begin
      failures++; $display("FAIL xb_reg31 got=%h exp=00", reg_rd_data);
    end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    resetn      = 1'b0;
    sioc        = 1'b1;
    m_sda       = 1'b1;
    reg_rd_addr = 8'h00;
    wait_n(5);
    test_reset();
    resetn = 1'b1;
    wait_n(5);
    test_write();
    test_wrong_id();
    test_read();
    test_stop_repstart();
    test_reset_mid();
`ifdef SCCB_RESP_AUTOINC_EN
    test_autoinc();
`else
    test_extra_byte();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
